// File: rtl/haze_decode_pkg.sv
// Shared decode definitions: RV32I/RV64I opcodes, immediate kinds and skid-buffer states.
package haze_decode_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_type_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // OP-IMM func3 codes for SLLI and SRLI/SRAI carry a shift amount, not an I immediate.
    function automatic logic is_shift_func3(input logic [2:0] func3);
        return (func3 == 3'b001) || (func3 == 3'b101);
    endfunction

endpackage

// File: rtl/immediate_generator.sv
// Combinational immediate selection, XLEN sign/zero extension and illegal-encoding detection.
module immediate_generator
    import haze_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_Instruction,
    output imm_type_t       o_ImmType,
    output logic [XLEN-1:0] o_Imm,
    output logic            o_Illegal
);

    logic [6:0] opcode;
    logic [2:0] func3;

    assign opcode = i_Instruction[6:0];
    assign func3  = i_Instruction[14:12];

    always_comb begin
        o_ImmType = IMM_NONE;
        o_Imm     = '0;
        o_Illegal = 1'b0;
        // Every listed opcode ends in 2'b11, so the default arm also catches compressed encodings.
        case (opcode)
            OP_LOAD: begin
                o_ImmType = IMM_I;
                o_Imm     = XLEN'($signed(i_Instruction[31:20]));
            end
            OP_JALR: begin
                if (func3 != 3'b000) begin
                    o_Illegal = 1'b1;
                end else begin
                    o_ImmType = IMM_I;
                    o_Imm     = XLEN'($signed(i_Instruction[31:20]));
                end
            end
            OP_IMM: begin
                if (is_shift_func3(func3)) begin
                    o_ImmType = IMM_SHAMT;
                    if (XLEN == 64) o_Imm = XLEN'(i_Instruction[25:20]);
                    else            o_Imm = XLEN'(i_Instruction[24:20]);
                end else begin
                    o_ImmType = IMM_I;
                    o_Imm     = XLEN'($signed(i_Instruction[31:20]));
                end
            end
            OP_STORE: begin
                o_ImmType = IMM_S;
                o_Imm     = XLEN'($signed({i_Instruction[31:25], i_Instruction[11:7]}));
            end
            OP_BRANCH: begin
                if (func3 == 3'b010 || func3 == 3'b011) begin
                    o_Illegal = 1'b1;
                end else begin
                    o_ImmType = IMM_B;
                    o_Imm     = XLEN'($signed({i_Instruction[31], i_Instruction[7],
                                               i_Instruction[30:25], i_Instruction[11:8], 1'b0}));
                end
            end
            OP_LUI, OP_AUIPC: begin
                o_ImmType = IMM_U;
                o_Imm     = XLEN'($signed({i_Instruction[31:12], 12'b0}));
            end
            OP_JAL: begin
                o_ImmType = IMM_J;
                o_Imm     = XLEN'($signed({i_Instruction[31], i_Instruction[19:12],
                                           i_Instruction[20], i_Instruction[30:21], 1'b0}));
            end
            OP_OP, OP_MISC_MEM, OP_SYSTEM: begin
                o_ImmType = IMM_NONE;
            end
            default: begin
                o_Illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: combinational decode captured into a main register backed by one skid slot.
module decode_stage
    import haze_decode_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_nReset,
    input  logic                   i_Flush,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [31:0]            i_Instruction,
    input  logic [XLEN-1:0]        i_PC,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [XLEN-1:0]        o_PC,
    output logic [6:0]             o_Opcode,
    output logic [4:0]             o_RD,
    output logic [4:0]             o_RS1,
    output logic [4:0]             o_RS2,
    output logic [2:0]             o_Func3,
    output logic [6:0]             o_Func7,
    output imm_type_t              o_ImmType,
    output logic [XLEN-1:0]        o_Imm,
    output logic                   o_Illegal,
    output logic [COUNT_WIDTH-1:0] o_DecodeCount
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        imm_type_t       imm_type;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } decoded_bundle_t;

    imm_type_t        imm_type;
    logic [XLEN-1:0]  imm;
    logic             illegal;
    decoded_bundle_t  decoded;

    skid_state_t            state_reg;
    decoded_bundle_t        main_reg;
    decoded_bundle_t        skid_reg;
    logic                   valid_reg;
    logic                   ready_reg;
    logic [COUNT_WIDTH-1:0] count_reg;

    logic accept;
    logic handoff;

    immediate_generator #(.XLEN(XLEN)) u_immediate_generator (
        .i_Instruction (i_Instruction),
        .o_ImmType     (imm_type),
        .o_Imm         (imm),
        .o_Illegal     (illegal)
    );

    always_comb begin
        decoded          = '0;
        decoded.pc       = i_PC;
        decoded.opcode   = i_Instruction[6:0];
        decoded.rd       = i_Instruction[11:7];
        decoded.rs1      = i_Instruction[19:15];
        decoded.rs2      = i_Instruction[24:20];
        decoded.func3    = i_Instruction[14:12];
        decoded.func7    = i_Instruction[31:25];
        decoded.imm_type = imm_type;
        decoded.imm      = imm;
        decoded.illegal  = illegal;
    end

    assign accept  = i_Valid && ready_reg;
    assign handoff = valid_reg && i_Ready;

    always_ff @(posedge i_Clock) begin
        if (!i_nReset) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            count_reg <= '0;
        end else begin
            // A hand-off completes on this edge even if a flush discards everything else.
            if (handoff) count_reg <= count_reg + COUNT_WIDTH'(1);
            if (i_Flush) begin
                state_reg <= EMPTY;
                valid_reg <= 1'b0;
                ready_reg <= 1'b1;
            end else begin
                case (state_reg)
                    EMPTY: begin
                        if (accept) begin
                            main_reg  <= decoded;
                            state_reg <= ONE;
                            valid_reg <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && handoff) begin
                            main_reg <= decoded;
                        end else if (accept) begin
                            skid_reg  <= decoded;
                            state_reg <= TWO;
                            ready_reg <= 1'b0;
                        end else if (handoff) begin
                            state_reg <= EMPTY;
                            valid_reg <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (handoff) begin
                            main_reg  <= skid_reg;
                            state_reg <= ONE;
                            ready_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= EMPTY;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_Valid       = valid_reg;
    assign o_Ready       = ready_reg;
    assign o_PC          = main_reg.pc;
    assign o_Opcode      = main_reg.opcode;
    assign o_RD          = main_reg.rd;
    assign o_RS1         = main_reg.rs1;
    assign o_RS2         = main_reg.rs2;
    assign o_Func3       = main_reg.func3;
    assign o_Func7       = main_reg.func7;
    assign o_ImmType     = main_reg.imm_type;
    assign o_Imm         = main_reg.imm;
    assign o_Illegal     = main_reg.illegal;
    assign o_DecodeCount = count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: XLEN=32 and XLEN=64 instances share stimulus, COUNT_WIDTH=4.
module tb_decode_stage;
    import haze_decode_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_nReset, i_Flush, i_Valid, i_Ready;
    logic [31:0] i_Instruction, i_PC;
    logic [63:0] pc64;
    assign pc64 = {32'h0, i_PC};

    logic        o_Ready, o_Valid, o_Illegal;
    logic [31:0] o_PC, o_Imm;
    logic [6:0]  o_Opcode, o_Func7;
    logic [4:0]  o_RD, o_RS1, o_RS2;
    logic [2:0]  o_Func3;
    imm_type_t   o_ImmType;
    logic [3:0]  o_DecodeCount;

    logic        r64, v64, ill64;
    logic [63:0] pc_o64, imm64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64;
    imm_type_t   it64;
    logic [3:0]  cnt64;

    decode_stage #(.XLEN(32), .COUNT_WIDTH(4)) dut (
        .i_Clock(clk), .i_nReset(i_nReset), .i_Flush(i_Flush), .i_Valid(i_Valid),
        .o_Ready(o_Ready), .i_Instruction(i_Instruction), .i_PC(i_PC), .o_Valid(o_Valid),
        .i_Ready(i_Ready), .o_PC(o_PC), .o_Opcode(o_Opcode), .o_RD(o_RD), .o_RS1(o_RS1),
        .o_RS2(o_RS2), .o_Func3(o_Func3), .o_Func7(o_Func7), .o_ImmType(o_ImmType),
        .o_Imm(o_Imm), .o_Illegal(o_Illegal), .o_DecodeCount(o_DecodeCount)
    );

    decode_stage #(.XLEN(64), .COUNT_WIDTH(4)) dut64 (
        .i_Clock(clk), .i_nReset(i_nReset), .i_Flush(i_Flush), .i_Valid(i_Valid),
        .o_Ready(r64), .i_Instruction(i_Instruction), .i_PC(pc64), .o_Valid(v64),
        .i_Ready(i_Ready), .o_PC(pc_o64), .o_Opcode(opc64), .o_RD(rd64), .o_RS1(rs1_64),
        .o_RS2(rs2_64), .o_Func3(f3_64), .o_Func7(f7_64), .o_ImmType(it64),
        .o_Imm(imm64), .o_Illegal(ill64), .o_DecodeCount(cnt64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        imm_type_t   itype;
        logic [31:0] imm;
        logic [63:0] imm64;
        logic        illegal;
    } exp_t;

    exp_t        expq[$];
    int          checks   = 0;
    int          errors   = 0;
    int          handoffs = 0;
    logic [31:0] pc_ctr   = 32'h0000_1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] instr, input logic [4:0] rd, input imm_type_t it,
                                input logic [31:0] imm, input logic [63:0] imm_wide, input logic ill);
        exp_t e;
        e.instr = instr; e.pc = 32'h0; e.rd = rd; e.itype = it;
        e.imm = imm; e.imm64 = imm_wide; e.illegal = ill;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input exp_t e_in);
        exp_t e;
        e = e_in;
        e.pc = pc_ctr;
        pc_ctr += 32'd4;
        i_Valid = 1'b1;
        i_Instruction = e.instr;
        i_PC = e.pc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_Ready) begin
                expq.push_back(e);
                @(posedge clk); #1;
                i_Valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL accept_timeout actual=no_ready required=ready instr=%08h", e.instr);
        i_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string name, input logic [3:0] req);
        @(negedge clk);
        check(name, o_DecodeCount, req);
        check({name, "_64"}, cnt64, req);
        @(posedge clk); #1;
    endtask

    // Monitor: compares whatever is presented against the queue head, pops on hand-off.
    always @(negedge clk) begin
        exp_t e;
        if (i_nReset) begin
            check("valid64", v64, o_Valid);
            if (o_Valid) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bundle actual=pc_%08h required=none", o_PC);
                end else begin
                    e = expq[0];
                    check("pc", o_PC, e.pc);
                    check("opcode", o_Opcode, e.instr[6:0]);
                    check("rd", o_RD, e.rd);
                    check("imm_type", o_ImmType, e.itype);
                    check("imm", o_Imm, e.imm);
                    check("illegal", o_Illegal, e.illegal);
                    check("imm64", imm64, e.imm64);
                    if (i_Ready) begin
                        void'(expq.pop_front());
                        handoffs++;
                        $display("handoff instr=%08h pc=%08h imm=%08h illegal=%0b",
                                 e.instr, o_PC, o_Imm, o_Illegal);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    exp_t tbl[9];
    exp_t ea, eb, ec;

    initial begin
        i_nReset = 1'b0; i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b0;
        i_Instruction = 32'h0; i_PC = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_Valid, 1'b0);
        check("rst_ready", o_Ready, 1'b1);
        check("rst_count", o_DecodeCount, 4'd0);
        check("rst_imm", o_Imm, 32'h0);
        check("rst_rd", o_RD, 5'd0);
        @(posedge clk); #1;
        i_nReset = 1'b1;
        i_Ready  = 1'b1;

        // addi x1,x0,-1
        send(mk(32'hFFF00093, 5'd1, IMM_I, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0));
        idle(3);
        chk_count("count_first", 4'd1);

        tbl[0] = mk(32'hFE000EE3, 5'd29, IMM_B, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        tbl[1] = mk(32'h123452B7, 5'd5, IMM_U, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
        tbl[2] = mk(32'h0020A423, 5'd8, IMM_S, 32'h0000_0008, 64'h8, 1'b0);
        tbl[3] = mk(32'hFF9FF0EF, 5'd1, IMM_J, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        tbl[4] = mk(32'h00000000, 5'd0, IMM_NONE, 32'h0, 64'h0, 1'b1);
        tbl[5] = mk(32'h00002067, 5'd0, IMM_NONE, 32'h0, 64'h0, 1'b1);
        tbl[6] = mk(32'h00002063, 5'd0, IMM_NONE, 32'h0, 64'h0, 1'b1);
        tbl[7] = mk(32'h00A09093, 5'd1, IMM_SHAMT, 32'd10, 64'd10, 1'b0);
        tbl[8] = mk(32'h002081B3, 5'd3, IMM_NONE, 32'h0, 64'h0, 1'b0);
        for (int k = 0; k < 9; k++) send(tbl[k]);
        idle(3);
        chk_count("count_vectors", 4'd10);

        // Backpressure: A and B fill main and skid, C waits for space.
        i_Ready = 1'b0;
        send(mk(32'h00100113, 5'd2, IMM_I, 32'd1, 64'd1, 1'b0));
        send(mk(32'h00200193, 5'd3, IMM_I, 32'd2, 64'd2, 1'b0));
        @(negedge clk);
        check("bp_ready_low", o_Ready, 1'b0);
        check("bp_valid", o_Valid, 1'b1);
        check("bp_hold_a", o_RD, 5'd2);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_a", o_RD, 5'd2);
        end
        @(posedge clk); #1;
        ec = mk(32'h00300213, 5'd4, IMM_I, 32'd3, 64'd3, 1'b0);
        ec.pc = pc_ctr; pc_ctr += 32'd4;
        i_Ready = 1'b1; i_Valid = 1'b1; i_Instruction = ec.instr; i_PC = ec.pc;
        @(negedge clk);
        check("bp_a_out", o_RD, 5'd2);
        check("bp_ready_still_low", o_Ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_b_next", o_RD, 5'd3);
        check("bp_ready_back", o_Ready, 1'b1);
        expq.push_back(ec);
        @(posedge clk); #1;
        i_Valid = 1'b0;
        @(negedge clk);
        check("bp_c_next", o_RD, 5'd4);
        @(posedge clk); #1;
        idle(3);
        chk_count("count_bp", 4'd13);

        // Flush while full, with a new word offered in the same cycle.
        i_Ready = 1'b0;
        send(mk(32'h00500293, 5'd5, IMM_I, 32'd5, 64'd5, 1'b0));
        send(mk(32'h00600313, 5'd6, IMM_I, 32'd6, 64'd6, 1'b0));
        i_Flush = 1'b1; i_Valid = 1'b1; i_Instruction = 32'h00700393; i_PC = pc_ctr;
        @(posedge clk); #1;
        i_Flush = 1'b0; i_Valid = 1'b0;
        expq.delete();
        @(negedge clk);
        check("flush_valid", o_Valid, 1'b0);
        check("flush_ready", o_Ready, 1'b1);
        check("flush_count", o_DecodeCount, 4'd13);
        @(posedge clk); #1;
        i_Ready = 1'b1;
        idle(4);
        chk_count("count_after_flush", 4'd13);

        // Reset mid-stream with both slots occupied.
        i_Ready = 1'b0;
        send(mk(32'h00500293, 5'd5, IMM_I, 32'd5, 64'd5, 1'b0));
        send(mk(32'h00600313, 5'd6, IMM_I, 32'd6, 64'd6, 1'b0));
        i_nReset = 1'b0;
        @(posedge clk); #1;
        i_nReset = 1'b1;
        expq.delete();
        handoffs = 0;
        @(negedge clk);
        check("mid_rst_valid", o_Valid, 1'b0);
        check("mid_rst_ready", o_Ready, 1'b1);
        check("mid_rst_count", o_DecodeCount, 4'd0);
        check("mid_rst_rd", o_RD, 5'd0);
        @(posedge clk); #1;

        // Counter wrap at 2^4 hand-offs.
        i_Ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [11:0] imm12;
            logic [4:0]  rdk;
            imm12 = 12'(k);
            rdk   = 5'(k);
            send(mk({imm12, 5'd0, 3'd0, rdk, 7'h13}, rdk, IMM_I, 32'(k), 64'(k), 1'b0));
            if (k == 15) begin
                idle(3);
                chk_count("count_15", 4'd15);
            end
        end
        idle(3);
        chk_count("count_wrap", 4'd0);
        check("handoffs_since_reset", handoffs, 16);
        check("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
